// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants: register width, register index width and the
// hardwired-zero register index.
package riscv_pkg;
   localparam int         XLEN       = 32;
   localparam int         REG_ADDR_W = 5;
   localparam logic [4:0] REG_ZERO   = 5'd0;
endpackage

// File: rtl/regfile_scoreboard.sv
// Writeback scoreboard: one pending bit per architectural register, the issue
// handshake and a running count of registers awaiting writeback.
module regfile_scoreboard
   import riscv_pkg::*;
#(
   parameter int ADDR_WIDTH = REG_ADDR_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wr_en,
   input  logic [ADDR_WIDTH-1:0]        wr_addr,
   input  logic                         issue_valid,
   input  logic [ADDR_WIDTH-1:0]        issue_addr,
   output logic                         issue_ready,
   output logic [(2**ADDR_WIDTH)-1:0]   busy_vec,
   output logic [ADDR_WIDTH:0]          busy_count
);
   localparam int                    DEPTH    = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);
   localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);

   logic [DEPTH-1:0]  busy_reg;
   logic [DEPTH-1:0]  busy_next;
   logic [ADDR_WIDTH:0] count_reg;
   logic              set_hit;
   logic              clr_hit;

   // A writeback in the same cycle retires the old reservation, so re-issue is allowed.
   assign issue_ready = !busy_reg[issue_addr] || (wr_en && (wr_addr == issue_addr));
   assign set_hit     = issue_valid && issue_ready && (issue_addr != ZERO_IDX);
   // Only a write that actually retires a pending bit moves the count.
   assign clr_hit     = wr_en && (wr_addr != ZERO_IDX) && busy_reg[wr_addr];

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_busy
         assign busy_next[gi] = (set_hit && (issue_addr == ADDR_WIDTH'(gi))) ? 1'b1 :
                                (wr_en && (wr_addr == ADDR_WIDTH'(gi)))      ? 1'b0 :
                                busy_reg[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_reg  <= '0;
         count_reg <= '0;
      end else begin
         busy_reg <= busy_next;
         if (set_hit && !clr_hit)
            count_reg <= count_reg + CNT_ONE;
         else if (clr_hit && !set_hit)
            count_reg <= count_reg - CNT_ONE;
      end
   end

   assign busy_vec   = busy_reg;
   assign busy_count = count_reg;
endmodule

// File: rtl/risc_v_regfile_sb.sv
// Integer register file (x0 hardwired to zero) with NUM_RD combinational read
// ports, one write port, optional write bypass and an integrated scoreboard.
module risc_v_regfile_sb
   import riscv_pkg::*;
#(
   parameter int DATA_WIDTH = XLEN,
   parameter int ADDR_WIDTH = REG_ADDR_W,
   parameter int NUM_RD     = 2,
   parameter int BYPASS     = 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr,
   output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data,
   output logic [NUM_RD-1:0]              rd_busy,
   input  logic                           wr_en,
   input  logic [ADDR_WIDTH-1:0]          wr_addr,
   input  logic [DATA_WIDTH-1:0]          wr_data,
   input  logic                           issue_valid,
   input  logic [ADDR_WIDTH-1:0]          issue_addr,
   output logic                           issue_ready,
   output logic [ADDR_WIDTH:0]            busy_count
);
   localparam int                    DEPTH     = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ZERO_IDX  = ADDR_WIDTH'(REG_ZERO);
   localparam logic                  BYPASS_EN = (BYPASS != 0);

   logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
   logic [DEPTH-1:0]      busy_vec;
   logic                  wr_hit;

   assign wr_hit = wr_en && (wr_addr != ZERO_IDX);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            mem_reg[i] <= '0;
      end else if (wr_hit) begin
         mem_reg[wr_addr] <= wr_data;
      end
   end

   regfile_scoreboard #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_sb (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .issue_valid (issue_valid),
      .issue_addr  (issue_addr),
      .issue_ready (issue_ready),
      .busy_vec    (busy_vec),
      .busy_count  (busy_count)
   );

   genvar gi;
   generate
      for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
         logic [ADDR_WIDTH-1:0] addr;
         logic                  byp;
         assign addr = rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
         assign byp  = BYPASS_EN && wr_hit && (wr_addr == addr);
         assign rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = (addr == ZERO_IDX) ? '0      :
                                                       byp                ? wr_data :
                                                       mem_reg[addr];
         assign rd_busy[gi] = (addr != ZERO_IDX) && !byp && busy_vec[addr];
      end
   endgenerate
endmodule

// File: tb/tb_risc_v_regfile_sb.sv
// Directed bench for risc_v_regfile_sb: a bypassing and a non-bypassing
// instance share stimulus; vectors are table-driven, corner cases hand-written.
module tb_risc_v_regfile_sb;
   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data, rd_data_nb;
   logic [1:0]  rd_busy, rd_busy_nb;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        issue_valid;
   logic [4:0]  issue_addr;
   logic        issue_ready, issue_ready_nb;
   logic [5:0]  busy_count, busy_count_nb;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   risc_v_regfile_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2), .BYPASS(1)) u_dut (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .issue_valid(issue_valid), .issue_addr(issue_addr),
      .issue_ready(issue_ready), .busy_count(busy_count)
   );

   risc_v_regfile_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2), .BYPASS(0)) u_dut_nb (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .issue_valid(issue_valid), .issue_addr(issue_addr),
      .issue_ready(issue_ready_nb), .busy_count(busy_count_nb)
   );

   typedef struct {
      logic        wr_en;
      logic [4:0]  wr_addr;
      logic [31:0] wr_data;
      logic        iv;
      logic [4:0]  ia;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [31:0] e_rd0;
      logic        e_b0;
      logic [31:0] e_rd1;
      logic        e_b1;
      logic [31:0] n_rd0;
      logic        n_b0;
      logic [31:0] n_rd1;
      logic        n_b1;
      logic        e_rdy;
      logic [5:0]  e_cnt;
   } vec_t;

   vec_t vecs [19];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      issue_valid = 1'b0; issue_addr = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      rd_addr = '0;
      idle_inputs();

      vecs[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 5, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 1, 0};
      vecs[1]  = '{0, 0, 0, 0, 0, 5, 0, 32'hDEADBEEF, 0, 0, 0, 32'hDEADBEEF, 0, 0, 0, 1, 0};
      vecs[2]  = '{1, 0, 32'h1234, 0, 0, 0, 5, 0, 0, 32'hDEADBEEF, 0, 0, 0, 32'hDEADBEEF, 0, 1, 0};
      vecs[3]  = '{0, 0, 0, 0, 0, 0, 5, 0, 0, 32'hDEADBEEF, 0, 0, 0, 32'hDEADBEEF, 0, 1, 0};
      vecs[4]  = '{1, 7, 32'hA5A5A5A5, 0, 0, 7, 5, 32'hA5A5A5A5, 0, 32'hDEADBEEF, 0, 0, 0, 32'hDEADBEEF, 0, 1, 0};
      vecs[5]  = '{0, 0, 0, 0, 0, 7, 5, 32'hA5A5A5A5, 0, 32'hDEADBEEF, 0, 32'hA5A5A5A5, 0, 32'hDEADBEEF, 0, 1, 0};
      vecs[6]  = '{0, 0, 0, 1, 3, 3, 7, 0, 0, 32'hA5A5A5A5, 0, 0, 0, 32'hA5A5A5A5, 0, 1, 1};
      vecs[7]  = '{0, 0, 0, 1, 3, 3, 7, 0, 1, 32'hA5A5A5A5, 0, 0, 1, 32'hA5A5A5A5, 0, 0, 1};
      vecs[8]  = '{1, 3, 32'h33, 0, 3, 3, 0, 32'h33, 0, 0, 0, 0, 1, 0, 0, 1, 0};
      vecs[9]  = '{0, 0, 0, 0, 3, 3, 0, 32'h33, 0, 0, 0, 32'h33, 0, 0, 0, 1, 0};
      vecs[10] = '{0, 0, 0, 1, 3, 3, 0, 32'h33, 0, 0, 0, 32'h33, 0, 0, 0, 1, 1};
      vecs[11] = '{1, 3, 32'h44, 1, 3, 3, 0, 32'h44, 0, 0, 0, 32'h33, 1, 0, 0, 1, 1};
      vecs[12] = '{0, 0, 0, 0, 3, 3, 0, 32'h44, 1, 0, 0, 32'h44, 1, 0, 0, 0, 1};
      vecs[13] = '{1, 9, 32'h99, 0, 0, 9, 3, 32'h99, 0, 32'h44, 1, 0, 0, 32'h44, 1, 1, 1};
      vecs[14] = '{1, 3, 32'h55, 0, 0, 9, 3, 32'h99, 0, 32'h55, 0, 32'h99, 0, 32'h44, 1, 1, 0};
      vecs[15] = '{0, 0, 0, 1, 0, 0, 3, 0, 0, 32'h55, 0, 0, 0, 32'h55, 0, 1, 0};
      vecs[16] = '{0, 0, 0, 1, 4, 4, 6, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
      vecs[17] = '{1, 4, 32'h4444, 1, 6, 4, 6, 32'h4444, 0, 0, 0, 0, 1, 0, 0, 1, 1};
      vecs[18] = '{1, 6, 32'h6666, 0, 0, 4, 6, 32'h4444, 0, 32'h6666, 0, 32'h4444, 0, 0, 1, 1, 0};

      // Random writes and reservations, then a reset edge that also carries a write and an issue.
      step();
      for (int i = 0; i < 8; i++) begin
         wr_en = 1'b1; wr_addr = 5'($urandom_range(1, 31)); wr_data = $urandom;
         issue_valid = 1'b1; issue_addr = 5'($urandom_range(1, 31));
         step();
      end
      rst = 1'b1;
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hFFFF_FFFF;
      issue_valid = 1'b1; issue_addr = 5'd8;
      step();
      rst = 1'b0;
      idle_inputs();
      #1;
      chk("reset_count", 32'(busy_count), 32'd0);
      chk("reset_count_nb", 32'(busy_count_nb), 32'd0);
      for (int i = 0; i < 32; i += 2) begin
         rd_addr = {5'(i + 1), 5'(i)};
         #1;
         chk($sformatf("reset_rd x%0d", i), rd_data[31:0], 32'd0);
         chk($sformatf("reset_rd x%0d", i + 1), rd_data[63:32], 32'd0);
         chk($sformatf("reset_busy x%0d/x%0d", i, i + 1), 32'(rd_busy), 32'd0);
      end
      $display("reset sequence: count=%0d", busy_count);

      for (int v = 0; v < 19; v++) begin
         wr_en = vecs[v].wr_en; wr_addr = vecs[v].wr_addr; wr_data = vecs[v].wr_data;
         issue_valid = vecs[v].iv; issue_addr = vecs[v].ia;
         rd_addr = {vecs[v].ra1, vecs[v].ra0};
         #1;
         chk($sformatf("v%0d rd0", v), rd_data[31:0], vecs[v].e_rd0);
         chk($sformatf("v%0d rd1", v), rd_data[63:32], vecs[v].e_rd1);
         chk($sformatf("v%0d busy0", v), 32'(rd_busy[0]), 32'(vecs[v].e_b0));
         chk($sformatf("v%0d busy1", v), 32'(rd_busy[1]), 32'(vecs[v].e_b1));
         chk($sformatf("v%0d nb_rd0", v), rd_data_nb[31:0], vecs[v].n_rd0);
         chk($sformatf("v%0d nb_rd1", v), rd_data_nb[63:32], vecs[v].n_rd1);
         chk($sformatf("v%0d nb_busy0", v), 32'(rd_busy_nb[0]), 32'(vecs[v].n_b0));
         chk($sformatf("v%0d nb_busy1", v), 32'(rd_busy_nb[1]), 32'(vecs[v].n_b1));
         chk($sformatf("v%0d ready", v), 32'(issue_ready), 32'(vecs[v].e_rdy));
         chk($sformatf("v%0d nb_ready", v), 32'(issue_ready_nb), 32'(vecs[v].e_rdy));
         $display("vec %0d wr=%0d@x%0d iss=%0d@x%0d rd0=%h rd1=%h busy=%b ready=%0d",
                  v, wr_en, wr_addr, issue_valid, issue_addr,
                  rd_data[31:0], rd_data[63:32], rd_busy, issue_ready);
         step();
         chk($sformatf("v%0d count", v), 32'(busy_count), 32'(vecs[v].e_cnt));
         chk($sformatf("v%0d nb_count", v), 32'(busy_count_nb), 32'(vecs[v].e_cnt));
      end
      idle_inputs();

      // Back-to-back reservations interrupted by reset.
      for (int i = 1; i <= 10; i++) begin
         issue_valid = 1'b1; issue_addr = 5'(i);
         #1;
         chk($sformatf("pre_rst ready x%0d", i), 32'(issue_ready), 32'd1);
         step();
      end
      chk("pre_rst count", 32'(busy_count), 32'd10);
      $display("issue x1..x10: count=%0d", busy_count);
      rst = 1'b1; issue_addr = 5'd11;
      step();
      rst = 1'b0;
      idle_inputs();
      #1;
      chk("mid_rst count", 32'(busy_count), 32'd0);
      for (int i = 0; i < 32; i++) begin
         issue_addr = 5'(i);
         #1;
         chk($sformatf("post_rst ready x%0d", i), 32'(issue_ready), 32'd1);
      end
      $display("mid-sequence reset: count=%0d", busy_count);

      // Fill the whole scoreboard; the count must saturate at 31 without wrapping.
      for (int i = 1; i <= 31; i++) begin
         issue_valid = 1'b1; issue_addr = 5'(i);
         step();
      end
      chk("full count", 32'(busy_count), 32'd31);
      issue_addr = 5'd31;
      rd_addr = {5'd0, 5'd31};
      #1;
      chk("full reissue ready", 32'(issue_ready), 32'd0);
      chk("full busy x31", 32'(rd_busy), 32'b01);
      step();
      chk("full count hold", 32'(busy_count), 32'd31);
      $display("issue x1..x31: count=%0d", busy_count);
      idle_inputs();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
